// File: rtl/wb_write_arbiter_pkg.sv
// rtl/wb_write_arbiter_pkg.sv - shared widths and queued-entry type for the writeback arbiter
package wb_write_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << REG_W;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
    return r == ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_long_fifo.sv
// rtl/wb_long_fifo.sv - in-order synchronous FIFO holding long-latency results
// awaiting the register-file write port.
module wb_long_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_push,
  input  wb_entry_t     i_din,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output wb_entry_t     o_head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only safe when the head leaves on the same edge.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline writeback and long-latency results onto
// the single register-file write port, with a pending-destination scoreboard.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PipeWrite,
  input  logic [REG_W-1:0]  PipeReg,
  input  logic [DATA_W-1:0] PipeData,
  input  logic              LongIssue,
  input  logic [REG_W-1:0]  LongIssueReg,
  input  logic              LongValid,
  input  logic [REG_W-1:0]  LongReg,
  input  logic [DATA_W-1:0] LongData,
  output logic              LongReady,
  output logic              Write1,
  output logic [REG_W-1:0]  WriteReg1,
  output logic [DATA_W-1:0] WriteData1,
  output logic [NREGS-1:0]  Pending,
  output logic              PipeStall,
  output logic [CW-1:0]     Count,
  output logic              Error
);

  localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT - 1);

  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  wb_entry_t         w_head;
  wb_entry_t         w_long;
  wb_entry_t         w_sel_entry;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_sel;
  logic              w_sel_long;
  logic              w_err;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_clr;
  logic [AGE_W-1:0]  w_age_next;

  logic              r_write1;
  logic [REG_W-1:0]  r_wreg;
  logic [DATA_W-1:0] r_wdata;
  logic [NREGS-1:0]  r_pending;
  logic [AGE_W-1:0]  r_age;
  logic              r_stall;
  logic              r_err;

  wb_long_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_din   (w_long),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign w_long    = '{rd: LongReg, data: LongData};
  assign LongReady = !w_full;
  assign w_accept  = LongValid && LongReady;

  // Pipe beats queued results, queued results beat a fresh result (which bypasses).
  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_sel       = 1'b0;
    w_sel_long  = 1'b0;
    w_sel_entry = '{rd: PipeReg, data: PipeData};
    if (PipeWrite) begin
      w_sel  = 1'b1;
      w_push = w_accept;
    end else if (!w_empty) begin
      w_sel       = 1'b1;
      w_sel_long  = 1'b1;
      w_pop       = 1'b1;
      w_push      = w_accept;
      w_sel_entry = w_head;
    end else if (w_accept) begin
      w_sel       = 1'b1;
      w_sel_long  = 1'b1;
      w_sel_entry = w_long;
    end
  end

  assign w_set = (LongIssue && !is_zero_reg(LongIssueReg)) ? (NREGS'(1) << LongIssueReg) : '0;
  assign w_clr = w_sel_long ? (NREGS'(1) << w_sel_entry.rd) : '0;

  assign w_err = (w_accept && !is_zero_reg(LongReg) && !r_pending[LongReg])
              || (LongIssue && !is_zero_reg(LongIssueReg) && r_pending[LongIssueReg])
              || (PipeWrite && r_pending[PipeReg]);

  // Age tracks how long the current head has been passed over; saturates at the stall threshold.
  assign w_age_next = (w_empty || w_pop) ? '0
                    : (r_age == AGE_MAX) ? r_age
                    : r_age + AGE_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_write1  <= 1'b0;
      r_wreg    <= '0;
      r_wdata   <= '0;
      r_pending <= '0;
      r_age     <= '0;
      r_stall   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_write1 <= w_sel && !is_zero_reg(w_sel_entry.rd);
      if (w_sel) begin
        r_wreg  <= w_sel_entry.rd;
        r_wdata <= w_sel_entry.data;
      end
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_age     <= w_age_next;
      r_stall   <= (w_age_next >= AGE_MAX);
      r_err     <= r_err | w_err;
    end
  end

  assign Write1     = r_write1;
  assign WriteReg1  = r_wreg;
  assign WriteData1 = r_wdata;
  assign Pending    = r_pending;
  assign PipeStall  = r_stall;
  assign Count      = w_count;
  assign Error      = r_err;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for wb_write_arbiter against a queue-based model
module tb_wb_write_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CW           = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RESET;
  logic          PipeWrite;
  logic [4:0]    PipeReg;
  logic [31:0]   PipeData;
  logic          LongIssue;
  logic [4:0]    LongIssueReg;
  logic          LongValid;
  logic [4:0]    LongReg;
  logic [31:0]   LongData;
  logic          LongReady;
  logic          Write1;
  logic [4:0]    WriteReg1;
  logic [31:0]   WriteData1;
  logic [31:0]   Pending;
  logic          PipeStall;
  logic [CW-1:0] Count;
  logic          Error;

  always #5 CLK = ~CLK;

  wb_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PipeWrite    (PipeWrite),
    .PipeReg      (PipeReg),
    .PipeData     (PipeData),
    .LongIssue    (LongIssue),
    .LongIssueReg (LongIssueReg),
    .LongValid    (LongValid),
    .LongReg      (LongReg),
    .LongData     (LongData),
    .LongReady    (LongReady),
    .Write1       (Write1),
    .WriteReg1    (WriteReg1),
    .WriteData1   (WriteData1),
    .Pending      (Pending),
    .PipeStall    (PipeStall),
    .Count        (Count),
    .Error        (Error)
  );

  typedef struct {
    bit        w;
    bit [4:0]  r;
    bit [31:0] d;
    bit [31:0] pend;
    int        cnt;
    bit        stall;
    bit        err;
  } exp_t;

  typedef struct {
    bit [4:0]  r;
    bit [31:0] d;
  } ent_t;

  exp_t      exp_q[$];
  exp_t      mon_e;
  ent_t      m_q[$];
  bit [31:0] m_pend;
  int        m_wait;
  bit        m_err;
  bit        m_stall;
  int        n_checks = 0;
  int        n_fail   = 0;
  int        outstanding[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per clock, reading the inputs about to be sampled.
  task automatic model_cycle(output exp_t e);
    bit   acc, sel, sel_long, had, popped;
    ent_t w, lg;
    w = '{r: 5'd0, d: 32'd0};
    if (RESET) begin
      m_q.delete();
      m_pend  = '0;
      m_wait  = 0;
      m_err   = 0;
      m_stall = 0;
      e = '{w: 0, r: 0, d: 0, pend: 0, cnt: 0, stall: 0, err: 0};
      return;
    end
    acc = LongValid && (m_q.size() < DEPTH);
    lg  = '{r: LongReg, d: LongData};
    if (acc && LongReg != 0 && !m_pend[LongReg]) m_err = 1;
    if (LongIssue && LongIssueReg != 0 && m_pend[LongIssueReg]) m_err = 1;
    if (PipeWrite && m_pend[PipeReg]) m_err = 1;
    sel = 0; sel_long = 0; popped = 0;
    had = (m_q.size() > 0);
    if (PipeWrite) begin
      sel = 1;
      w   = '{r: PipeReg, d: PipeData};
      if (acc) m_q.push_back(lg);
    end else if (m_q.size() > 0) begin
      sel = 1; sel_long = 1; popped = 1;
      w   = m_q.pop_front();
      if (acc) m_q.push_back(lg);
    end else if (acc) begin
      sel = 1; sel_long = 1;
      w   = lg;
    end
    m_wait = (had && !popped) ? m_wait + 1 : 0;
    if (sel_long) m_pend[w.r] = 1'b0;
    if (LongIssue && LongIssueReg != 0) m_pend[LongIssueReg] = 1'b1;
    m_stall = (m_wait >= STARVE_LIMIT - 1);
    e.w     = sel && (w.r != 0);
    e.r     = w.r;
    e.d     = w.d;
    e.pend  = m_pend;
    e.cnt   = m_q.size();
    e.stall = m_stall;
    e.err   = m_err;
  endtask

  task automatic step();
    exp_t e;
    model_cycle(e);
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle_inputs();
    PipeWrite = 0; PipeReg = 0; PipeData = 0;
    LongIssue = 0; LongIssueReg = 0;
    LongValid = 0; LongReg = 0; LongData = 0;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("Write1", 32'(Write1), 32'(mon_e.w));
      if (mon_e.w) begin
        chk("WriteReg1", 32'(WriteReg1), 32'(mon_e.r));
        chk("WriteData1", WriteData1, mon_e.d);
      end
      chk("Pending", Pending, mon_e.pend);
      chk("Count", 32'(Count), 32'(mon_e.cnt));
      chk("LongReady", 32'(LongReady), 32'(mon_e.cnt != DEPTH));
      chk("PipeStall", 32'(PipeStall), 32'(mon_e.stall));
      chk("Error", 32'(Error), 32'(mon_e.err));
    end
  end

  initial begin
    int r, guard, idx;
    bit accepted;
    idle_inputs();
    RESET = 1;
    PipeWrite = 1; PipeReg = 5'd5; PipeData = 32'h55;
    step(); step();
    RESET = 0;
    idle_inputs();
    step();

    // bypass
    LongIssue = 1; LongIssueReg = 5'd7; step();
    idle_inputs();
    LongValid = 1; LongReg = 5'd7; LongData = 32'hDEADBEEF; step();
    idle_inputs(); step();

    // pipe priority over a long result
    LongIssue = 1; LongIssueReg = 5'd3; step();
    LongIssueReg = 5'd4; step();
    idle_inputs();
    PipeWrite = 1; PipeReg = 5'd9; PipeData = 32'h11;
    LongValid = 1; LongReg = 5'd3; LongData = 32'h33; step();
    idle_inputs(); step(); step();
    LongValid = 1; LongReg = 5'd4; LongData = 32'h44; step();
    idle_inputs(); step();

    // full FIFO with the pipe hogging the port, then drain in order
    for (int i = 1; i <= 5; i++) begin
      LongIssue = 1; LongIssueReg = 5'(i); step();
    end
    idle_inputs();
    PipeWrite = 1; PipeReg = 5'd20; PipeData = 32'h2020;
    r = 1; guard = 0;
    while (r <= 5 && guard < 40) begin
      LongValid = 1; LongReg = 5'(r); LongData = 32'hA000_0000 + 32'(r);
      if (guard >= 8) PipeWrite = 0;
      accepted = (m_q.size() < DEPTH);
      step();
      if (accepted) r++;
      guard++;
    end
    chk("full_all_accepted", 32'(r), 32'd6);
    idle_inputs();
    for (int i = 0; i < 8; i++) step();

    // starvation
    LongIssue = 1; LongIssueReg = 5'd10; step();
    idle_inputs();
    PipeWrite = 1; PipeReg = 5'd21; PipeData = 32'h21;
    LongValid = 1; LongReg = 5'd10; LongData = 32'hCAFE; step();
    LongValid = 0;
    for (int i = 0; i < 9; i++) begin
      PipeData = 32'(i); step();
    end
    idle_inputs(); step(); step();

    // zero register and protocol error
    LongValid = 1; LongReg = 5'd0; LongData = 32'h0BAD; step();
    idle_inputs(); step();
    LongValid = 1; LongReg = 5'd12; LongData = 32'h12; step();
    idle_inputs(); step(); step();
    RESET = 1; step();
    RESET = 0; step();

    // legal random traffic
    outstanding.delete();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(1, 31);
        if (!m_pend[r]) begin LongIssue = 1; LongIssueReg = 5'(r); end
      end
      idx = -1;
      if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, outstanding.size() - 1);
        LongValid = 1; LongReg = 5'(outstanding[idx]); LongData = $urandom;
      end
      if (!m_stall && $urandom_range(0, 99) < 60) begin
        r = $urandom_range(0, 31);
        if (!m_pend[r] && !(LongIssue && LongIssueReg == 5'(r))) begin
          PipeWrite = 1; PipeReg = 5'(r); PipeData = $urandom;
        end
      end
      accepted = LongValid && (m_q.size() < DEPTH);
      step();
      if (accepted) outstanding.delete(idx);
      if (LongIssue) outstanding.push_back(int'(LongIssueReg));
    end

    // unconstrained traffic including violations and mid-run resets
    for (int c = 0; c < 300; c++) begin
      RESET        = ($urandom_range(0, 49) == 0);
      PipeWrite    = $urandom_range(0, 1);
      PipeReg      = 5'($urandom_range(0, 31));
      PipeData     = $urandom;
      LongIssue    = $urandom_range(0, 1);
      LongIssueReg = 5'($urandom_range(0, 31));
      LongValid    = $urandom_range(0, 1);
      LongReg      = 5'($urandom_range(0, 31));
      LongData     = $urandom;
      step();
    end
    RESET = 0;
    idle_inputs();
    for (int i = 0; i < 8; i++) step();

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Merges the in-order pipeline writeback stream and out-of-order long-latency results (multiply/divide, load-miss return) onto the register file's single write port (Write1/WriteReg1/WriteData1).
- Sits directly upstream of the register file.
- Keeps a pending-destination scoreboard that the ID stage uses to stall on operands whose long-latency producer has not yet written back.

Parameters:
- DEPTH, 4: long-result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 8: cycles the FIFO head may wait before PipeStall is raised.
- CW, 3: width of Count, equal to $clog2(DEPTH+1).

Ports:
- CLK  in  1  clock. One clock; reset is synchronous and active-high.
- RESET  in  1  synchronous, active-high reset.
- PipeWrite  in  1  pipeline WB write request; always accepted, no back-pressure.
- PipeReg  in  5  pipeline destination register.
- PipeData  in  32  pipeline write data.
- LongIssue  in  1  ID issues a long-latency op; marks its destination pending.
- LongIssueReg  in  5  destination register of the issued long op.
- LongValid  in  1  long result valid.
- LongReg  in  5  long result destination register.
- LongData  in  32  long result data.
- LongReady  out  1  arbiter can accept a long result this cycle.
- Write1  out  1  register-file write enable (registered).
- WriteReg1  out  5  register-file write address (registered).
- WriteData1  out  32  register-file write data (registered).
- Pending  out  32  scoreboard; bit r=1 means register r awaits a long result.
- PipeStall  out  1  request that upstream hold PipeWrite low next cycle.
- Count  out  CW  FIFO occupancy.
- Error  out  1  sticky protocol-violation flag.

Behaviour:
Reset
- In a cycle with RESET=1, all inputs are ignored.
- Next cycle: Write1=0, WriteReg1=0, WriteData1=0, Pending=0, Count=0, PipeStall=0, Error=0, FIFO empty, age counter 0.
- LongReady = (Count != DEPTH); it reads 1 after reset.
- Reset mid-operation discards FIFO contents and pending bits.

Long-result handshake
- A long result is accepted when LongValid && LongReady.
- LongReady is combinational from Count only. It does not depend on LongValid.

Write-port selection (evaluated each cycle; the chosen write appears on outputs the following cycle, latency 1)
- 1. PipeWrite=1: drive the pipe write. An accepted long result is enqueued.
- 2. Else if FIFO non-empty: pop the head and drive it. An accepted long result is enqueued in the same cycle; push and pop may occur together and Count is unchanged.
- 3. Else if the long result is accepted: bypass the FIFO and drive it directly. Count stays 0.
- 4. Else: Write1=0. WriteReg1/WriteData1 hold their previous values.

Register $zero
- Any write selected with register 0 drives Write1=0.
- It still consumes the handshake/FIFO slot.

Scoreboard
- LongIssue with LongIssueReg != 0 sets Pending[LongIssueReg].
- A long write driven to the port (rule 2 or 3) clears Pending[reg] on the same edge the outputs update.
- Same-cycle set and clear of the same register: set wins.

Starvation
- The age counter increments each cycle the FIFO is non-empty and the head is not popped. It resets to 0 on pop or when the FIFO is empty.
- PipeStall = (age >= STARVE_LIMIT-1), registered.
- If upstream ignores PipeStall, the pipe write still wins.

Error (sticky, cleared only by reset)
- LongValid accepted for a register whose Pending bit is 0 (register 0 excepted).
- LongIssue to a register already pending.
- PipeWrite to a pending register.

Ordering
- The FIFO is strictly in order.
- No merging or coalescing of writes to the same register.

Decomposition:
- Shared package/include (config.v): register-address width 5, data width 32, ZERO_REG=0.
- One natural sub-module: wb_long_fifo, a synchronous FIFO of DEPTH × {5-bit reg, 32-bit data}.
  - Signals: push, pop, full, empty, count, head.
  - Same-cycle push+pop is legal when non-empty.
- Arbitration, scoreboard, age counter and Error logic remain in wb_write_arbiter.

Test Plan:
- Reset → Write1=0, Pending=0, Count=0, LongReady=1, Error=0. Hold RESET=1 with PipeWrite=1 → no write emitted.
- Bypass: LongIssue reg 7, then LongValid reg 7 data 0xDEADBEEF with PipeWrite=0 → next cycle Write1=1, WriteReg1=7, WriteData1=0xDEADBEEF, Pending[7]=0, Count=0.
- Priority: issue regs 3 and 4, then PipeWrite reg 9 data 0x11 together with LongValid reg 3 data 0x33, then idle → cycle+1 writes reg 9 = 0x11, cycle+2 writes reg 3 = 0x33, Pending[3] clears at cycle+2.
- Full: issue regs 1–5, hold PipeWrite=1, present long results for 1–5 → LongReady=0 after four are accepted (Count=4). Reg 5 is accepted only after a pop; results drain in order 1, 2, 3, 4, 5.
- Starvation: one queued result with PipeWrite held high → PipeStall=1 after 7 waiting cycles. Drop PipeWrite → head written, PipeStall returns to 0.
- Zero/error: LongValid reg 0 → Write1=0 and Error stays 0. LongValid reg 12 with Pending[12]=0 → Error=1 and stays 1 until RESET.
